// File: rtl/mem_twoport_clr_pkg.sv
// Shared types for the self-clearing two-port scratch RAM.
// Holds the clear-sweep state encoding and the read-latency selector values.
package mem_pkg;

   typedef enum logic {CLEAR, READY} clr_state_t;

   localparam int RD_COMB = 0;
   localparam int RD_REG  = 1;

endpackage

// File: rtl/mem_twoport_clr_core.sv
// Bare storage array with one synchronous write port and one asynchronous read port.
// No reset on the array; initial content is established by the clear sweep in the top.
module mem_twoport_core #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [ADDR_W-1:0] i_ra,
   output logic [DATA_W-1:0] o_rd
);

   // Callers guarantee in-range addresses, so only the bits that select a word are used.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0]  w_wIdx;
   logic [IDX_W-1:0]  w_rIdx;

   assign w_wIdx = i_wa[IDX_W-1:0];
   assign w_rIdx = i_ra[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[w_wIdx] <= i_wd;
      end
   end

   assign o_rd = r_mem[w_rIdx];

endmodule

// File: rtl/mem_twoport_clr.sv
// Two-port scratch RAM with a self-clearing sweep after reset or on request,
// selectable read latency and same-address write-first/read-first behaviour.
module mem_twoport_clr
   import mem_pkg::*;
#(
   parameter int                DATA_W  = 20,
   parameter int                ADDR_W  = 9,
   parameter int                DEPTH   = 512,
   parameter int                RD_LAT  = 0,
   parameter int                BYPASS  = 1,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra,
   input  logic              re,
   input  logic [ADDR_W-1:0] wa,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   input  logic              clr_req,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic              busy
);

   if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_badDepth
      $error("mem_twoport_clr: DEPTH must be in 2..2**ADDR_W");
   end
   if (RD_LAT != RD_COMB && RD_LAT != RD_REG) begin : g_badRdLat
      $error("mem_twoport_clr: RD_LAT must be 0 or 1");
   end

   // One extra bit keeps the sweep counter from wrapping when DEPTH fills the address space.
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

   clr_state_t        r_state;
   logic [ADDR_W:0]   r_clrAddr;
   logic              w_busy;
   logic              w_waOk;
   logic              w_raOk;
   logic              w_portWe;
   logic              w_memWe;
   logic [ADDR_W-1:0] w_memWa;
   logic [DATA_W-1:0] w_memWd;
   logic [DATA_W-1:0] w_memRd;
   logic [DATA_W-1:0] w_rdData;

   assign w_busy   = (r_state == CLEAR);
   assign w_waOk   = ({1'b0, wa} < LP_DEPTH);
   assign w_raOk   = ({1'b0, ra} < LP_DEPTH);
   assign w_portWe = we & w_waOk & ~clr_req & ~w_busy;
   assign w_memWe  = rst_n & (w_busy | w_portWe);
   assign w_memWa  = w_busy ? r_clrAddr[ADDR_W-1:0] : wa;
   assign w_memWd  = w_busy ? CLR_VAL : d;
   assign busy     = w_busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= CLEAR;
         r_clrAddr <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clrAddr <= r_clrAddr + 1'b1;
               if (r_clrAddr == LP_LAST) begin
                  r_state <= READY;
               end
            end
            default: begin
               if (clr_req) begin
                  r_state   <= CLEAR;
                  r_clrAddr <= '0;
               end
            end
         endcase
      end
   end

   mem_twoport_core #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_core (
      .clk (clk),
      .i_we(w_memWe),
      .i_wa(w_memWa),
      .i_wd(w_memWd),
      .i_ra(ra),
      .o_rd(w_memRd)
   );

   // Write-first forwarding only applies when the port write will actually land.
   assign w_rdData = !w_raOk                                    ? '0 :
                     (BYPASS != 0 && w_portWe && (wa == ra))   ? d  : w_memRd;

   if (RD_LAT == RD_COMB) begin : g_combRead
      assign q       = w_busy ? CLR_VAL : w_rdData;
      assign q_valid = re & ~w_busy;
   end else begin : g_regRead
      logic [DATA_W-1:0] r_q;
      logic              r_qValid;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_q      <= '0;
            r_qValid <= 1'b0;
         end else if (re && !w_busy) begin
            r_q      <= w_rdData;
            r_qValid <= 1'b1;
         end else begin
            r_qValid <= 1'b0;
         end
      end

      assign q       = r_q;
      assign q_valid = r_qValid;
   end

endmodule

// File: tb/tb_mem_twoport_clr.sv
// Bench for mem_twoport_clr: two instances (combinational write-first, registered read-first)
// driven by one stimulus stream and checked against an array-based reference model.
module tb_mem_twoport_clr;

   localparam int                DW    = 20;
   localparam int                AW_A  = 4;
   localparam int                DEP_A = 8;
   localparam logic [DW-1:0]     CLR_A = 20'h0F0F0;
   localparam int                AW_B  = 3;
   localparam int                DEP_B = 6;
   localparam logic [DW-1:0]     CLR_B = 20'h3C3C3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          re = 1'b0;
   logic          we = 1'b0;
   logic          clrReq = 1'b0;
   logic [3:0]    ra = '0;
   logic [3:0]    wa = '0;
   logic [DW-1:0] d = '0;
   logic [DW-1:0] qA, qB;
   logic          qvA, qvB, busyA, busyB;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] memA [DEP_A];
   logic [DW-1:0] memB [DEP_B];
   int            busyCntA = 0;
   int            busyCntB = 0;
   logic [DW-1:0] qRegB = '0;
   logic          qvRegB = 1'b0;
   logic          modelValid = 1'b0;

   always #5 clk = ~clk;

   mem_twoport_clr #(
      .DATA_W(DW), .ADDR_W(AW_A), .DEPTH(DEP_A), .RD_LAT(0), .BYPASS(1), .CLR_VAL(CLR_A)
   ) dutA (
      .clk(clk), .rst_n(rst_n), .ra(ra), .re(re), .wa(wa), .we(we), .d(d),
      .clr_req(clrReq), .q(qA), .q_valid(qvA), .busy(busyA)
   );

   mem_twoport_clr #(
      .DATA_W(DW), .ADDR_W(AW_B), .DEPTH(DEP_B), .RD_LAT(1), .BYPASS(0), .CLR_VAL(CLR_B)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .ra(ra[2:0]), .re(re), .wa(wa[2:0]), .we(we), .d(d),
      .clr_req(clrReq), .q(qB), .q_valid(qvB), .busy(busyB)
   );

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus: drive, check outputs mid-cycle against the model, then advance the model.
   task automatic applyStimulus(input logic iRst, input logic iRe, input logic [3:0] iRa,
                                input logic iWe, input logic [3:0] iWa, input logic [DW-1:0] iD,
                                input logic iClr);
      logic [DW-1:0] expA;
      logic [2:0]    raB;
      logic [2:0]    waB;
      raB = iRa[2:0];
      waB = iWa[2:0];
      rst_n = iRst; re = iRe; ra = iRa; we = iWe; wa = iWa; d = iD; clrReq = iClr;
      @(negedge clk);
      if (modelValid) begin
         if (busyCntA > 0)                          expA = CLR_A;
         else if (int'(iRa) >= DEP_A)               expA = '0;
         else if (iWe && !iClr && iWa == iRa)       expA = iD;
         else                                       expA = memA[iRa[2:0]];
         checkOutput("A.busy",    20'(busyA), 20'(busyCntA > 0));
         checkOutput("A.q_valid", 20'(qvA),   20'(iRe && busyCntA == 0));
         checkOutput("A.q",       qA,         expA);
         checkOutput("B.busy",    20'(busyB), 20'(busyCntB > 0));
         checkOutput("B.q_valid", 20'(qvB),   20'(qvRegB));
         checkOutput("B.q",       qB,         qRegB);
      end
      if (!iRst) begin
         busyCntA = DEP_A;
         busyCntB = DEP_B;
         foreach (memA[i]) memA[i] = CLR_A;
         foreach (memB[i]) memB[i] = CLR_B;
         qRegB = '0;
         qvRegB = 1'b0;
         modelValid = 1'b1;
      end else begin
         if (busyCntA > 0) busyCntA--;
         else if (iClr) begin
            busyCntA = DEP_A;
            foreach (memA[i]) memA[i] = CLR_A;
         end else if (iWe && int'(iWa) < DEP_A) memA[iWa[2:0]] = iD;
         if (busyCntB > 0) begin
            busyCntB--;
            qvRegB = 1'b0;
         end else begin
            qvRegB = iRe;
            if (iRe) qRegB = (int'(raB) < DEP_B) ? memB[raB] : '0;
            if (iClr) begin
               busyCntB = DEP_B;
               foreach (memB[i]) memB[i] = CLR_B;
            end else if (iWe && int'(waB) < DEP_B) memB[waB] = iD;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b0);
   endtask

   task automatic readAll();
      for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b1, 4'(a), 1'b0, 4'd0, '0, 1'b0);
      idle(1);
   endtask

   initial begin
      logic [3:0] rAddr;
      logic [3:0] wAddr;
      @(posedge clk);
      #1;
      // Reset, full sweep, then every word reads back as the clear value.
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b0);
      idle(9);
      readAll();
      // Basic write then read.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 20'hABCDE, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, '0, 1'b0);
      idle(1);
      // Same-address collision.
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 20'h12345, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, '0, 1'b0);
      idle(1);
      // Clear beats a same-cycle write; port ops during the sweep are ignored.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 20'h00055, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 20'hFFFFF, 1'b1);
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b1, 1'b1, 4'(i), 1'b1, 4'(i), $urandom, 1'b0);
      readAll();
      // Reset in the middle of a sweep restarts it.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 20'h11111, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b1);
      idle(3);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, '0, 1'b0);
      idle(9);
      readAll();
      // Out-of-range writes and reads.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 20'h00777, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd12, 20'h00CCC, 1'b0);
      readAll();
      // Randomised traffic with occasional clears and resets.
      for (int i = 0; i < 400; i++) begin
         rAddr = 4'($urandom_range(0, 15));
         wAddr = ($urandom_range(0, 3) == 0) ? rAddr : 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), rAddr, 1'($urandom),
                       wAddr, 20'($urandom), ($urandom_range(0, 39) == 0));
      end
      idle(10);
      readAll();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
